// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access sequencer with valid/addr_ok/data_ok bus handshake
module mem_access_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid_i,
    input  logic [1:0]        mem_rw_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] fault_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              store_q;
    logic              unsigned_q;
    logic [DATA_W-1:0] wdata_q;
    logic              kill_q;
    logic              misalign_q;

    logic              is_mem_op;
    logic              start;
    logic              misaligned;
    logic              capture;
    logic              set_kill;
    logic [5:0]        lane_shift;
    logic [7:0]        base_mask;
    logic [DATA_W-1:0] raw_shifted;
    logic [DATA_W-1:0] load_val;

    assign is_mem_op  = (mem_rw_i == 2'b01) || (mem_rw_i == 2'b10);
    // resetn gates start so stall_o reads 0 while reset is held
    assign start      = resetn && valid_i && !flush_i && is_mem_op;
    assign lane_shift = {addr_q[2:0], 3'b000};

    always_comb begin
        case (size_i)
            2'd1:    misaligned = addr_i[0];
            2'd2:    misaligned = |addr_i[1:0];
            2'd3:    misaligned = |addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    always_comb begin
        raw_shifted = dresp_data >> lane_shift;
        case (size_q)
            2'd0: load_val = unsigned_q ? {{(DATA_W-8){1'b0}}, raw_shifted[7:0]}
                                        : {{(DATA_W-8){raw_shifted[7]}}, raw_shifted[7:0]};
            2'd1: load_val = unsigned_q ? {{(DATA_W-16){1'b0}}, raw_shifted[15:0]}
                                        : {{(DATA_W-16){raw_shifted[15]}}, raw_shifted[15:0]};
            2'd2: load_val = unsigned_q ? {{(DATA_W-32){1'b0}}, raw_shifted[31:0]}
                                        : {{(DATA_W-32){raw_shifted[31]}}, raw_shifted[31:0]};
            default: load_val = raw_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        misalign_o = 1'b0;
        dreq_valid = 1'b0;
        capture    = 1'b0;
        set_kill   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stall_o  = 1'b1;
                    state_nx = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                dreq_valid = 1'b1;
                stall_o    = 1'b1;
                set_kill   = flush_i;
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        // a flush arriving with the data still kills the result
                        if (kill_q || flush_i) begin
                            state_nx = S_IDLE;
                        end else begin
                            capture  = 1'b1;
                            state_nx = S_DONE;
                        end
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_o  = 1'b1;
                set_kill = flush_i;
                if (dresp_data_ok) begin
                    if (kill_q || flush_i) begin
                        state_nx = S_IDLE;
                    end else begin
                        capture  = 1'b1;
                        state_nx = S_DONE;
                    end
                end
            end
            default: begin
                if (!flush_i) begin
                    if (misalign_q) begin
                        misalign_o = 1'b1;
                    end else begin
                        done_o = 1'b1;
                    end
                end
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request fields come only from the latched copy, so they cannot move while waiting for addr_ok
    assign dreq_addr   = (state == S_REQ) ? addr_q : '0;
    assign dreq_size   = (state == S_REQ) ? size_q : 2'b00;
    assign dreq_strobe = (state == S_REQ && store_q) ? (base_mask << addr_q[2:0]) : 8'h00;
    assign dreq_data   = (state == S_REQ) ? (wdata_q << lane_shift) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q       <= '0;
            size_q       <= 2'b00;
            store_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            kill_q       <= 1'b0;
            misalign_q   <= 1'b0;
            rdata_o      <= '0;
            fault_addr_o <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_q     <= addr_i;
                size_q     <= size_i;
                store_q    <= (mem_rw_i == 2'b10);
                unsigned_q <= unsigned_i;
                wdata_q    <= wdata_i;
                misalign_q <= misaligned;
                if (misaligned) begin
                    fault_addr_o <= addr_i;
                end
            end
            kill_q <= (kill_q || set_kill) && (state_nx != S_IDLE);
            if (capture && !store_q) begin
                rdata_o <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - table-driven and randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk;
    logic        resetn;
    logic        valid_i;
    logic [1:0]  mem_rw_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        flush_i;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        stall_o;
    logic        done_o;
    logic [63:0] rdata_o;
    logic        misalign_o;
    logic [63:0] fault_addr_o;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .resetn(resetn), .valid_i(valid_i), .mem_rw_i(mem_rw_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .flush_i(flush_i), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .misalign_o(misalign_o), .fault_addr_o(fault_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rw;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] raw;
        int          aok;
        int          dok;
        int          fl_at;
        logic        fl_done;
        logic [7:0]  exp_strobe;
        logic [63:0] exp_data;
        logic [63:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] last_rdata = 64'd0;
    bit          rd_known = 1'b1;
    vec_t        table_v[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nb;
        int          off;
        logic [15:0] sm;
        logic [63:0] mask;
        logic [63:0] val;
        r    = v;
        nb   = 1 << v.size;
        off  = int'(v.addr % 64'd8);
        r.exp_mis = (v.addr % nb) != 0;
        sm = ((16'd1 << nb) - 16'd1) << off;
        r.exp_strobe = (v.rw == 2'b10) ? sm[7:0] : 8'h00;
        r.exp_data = v.wdata << (8 * off);
        val = v.raw >> (8 * off);
        if (nb < 8) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            val  = val & mask;
            if (!v.uns && val[8*nb-1]) val = val | ~mask;
        end
        r.exp_rdata = val;
        return r;
    endfunction

    task automatic run(input vec_t v);
        int stalls;
        int total;
        bit killed;
        @(posedge clk); #1;
        valid_i = 1'b1; mem_rw_i = v.rw; size_i = v.size; unsigned_i = v.uns;
        addr_i = v.addr; wdata_i = v.wdata; flush_i = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = v.raw;
        @(negedge clk);
        chk("start_stall", stall_o, 1);
        chk("start_no_req", dreq_valid, 0);
        @(posedge clk); #1;
        valid_i = 1'b0; addr_i = ~v.addr; wdata_i = ~v.wdata;
        if (v.exp_mis) begin
            flush_i = v.fl_done;
            @(negedge clk);
            chk("mis_pulse", misalign_o, !v.fl_done);
            chk("mis_fault_addr", fault_addr_o, v.addr);
            chk("mis_no_done", done_o, 0);
            chk("mis_no_req", dreq_valid, 0);
            chk("mis_stall", stall_o, 0);
            flush_i = 1'b0;
            return;
        end
        killed = 1'b0;
        stalls = 1;
        total  = v.aok + 1 + v.dok;
        for (int k = 0; k < total; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            flush_i = (k == v.fl_at);
            if (k == v.fl_at) killed = 1'b1;
            dresp_addr_ok = (k == v.aok);
            dresp_data_ok = (k == total - 1);
            @(negedge clk);
            stalls += int'(stall_o);
            if (k <= v.aok) begin
                chk("req_valid", dreq_valid, 1);
                chk("req_addr", dreq_addr, v.addr);
                chk("req_size", dreq_size, v.size);
                chk("req_strobe", dreq_strobe, v.exp_strobe);
                if (v.rw == 2'b10) chk("req_data", dreq_data, v.exp_data);
            end else begin
                chk("wait_no_req", dreq_valid, 0);
            end
        end
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush_i = v.fl_done;
        @(negedge clk);
        chk("stall_cycles", stalls, v.aok + v.dok + 2);
        chk("done_pulse", done_o, !killed && !v.fl_done);
        chk("end_stall", stall_o, 0);
        chk("end_no_mis", misalign_o, 0);
        if (v.rw == 2'b01 && !killed) begin
            chk("load_rdata", rdata_o, v.exp_rdata);
            last_rdata = v.exp_rdata;
            rd_known = 1'b1;
        end else if (v.rw == 2'b01 && rd_known) begin
            chk("killed_rdata_held", rdata_o, last_rdata);
        end else if (v.rw == 2'b10) begin
            rd_known = 1'b0;
        end
        flush_i = 1'b0;
    endtask

    initial begin
        vec_t rv;
        int   tot;

        //        rw     size  uns  addr          wdata                  raw                    aok dok fl  fd   strobe  data                   rdata                  mis
        table_v[0]  = '{2'b01, 2'd2, 1'b0, 64'h1004, 64'h0,               64'h8000_0001_0000_0000, 0, 0, -1, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_8000_0001, 1'b0};
        table_v[1]  = '{2'b10, 2'd0, 1'b0, 64'h2003, 64'hAB,              64'h0,                   0, 4, -1, 1'b0, 8'h08, 64'h0000_0000_AB00_0000, 64'h0,                 1'b0};
        table_v[2]  = '{2'b01, 2'd0, 1'b1, 64'h7,    64'h0,               64'h9C00_0000_0000_0000, 0, 0, -1, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_009C, 1'b0};
        table_v[3]  = '{2'b01, 2'd0, 1'b0, 64'h7,    64'h0,               64'h9C00_0000_0000_0000, 1, 1, -1, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF9C, 1'b0};
        table_v[4]  = '{2'b01, 2'd1, 1'b0, 64'h1001, 64'h0,               64'h0,                   0, 0, -1, 1'b0, 8'h00, 64'h0,                 64'h0,                 1'b1};
        table_v[5]  = '{2'b01, 2'd3, 1'b0, 64'h3000, 64'h0,               64'h1234_5678_9ABC_DEF0, 3, 2,  1, 1'b0, 8'h00, 64'h0,                 64'h0,                 1'b0};
        table_v[6]  = '{2'b10, 2'd3, 1'b0, 64'h10,   64'h1122_3344_5566_7788, 64'h0,               2, 0, -1, 1'b0, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                 1'b0};
        table_v[7]  = '{2'b10, 2'd1, 1'b0, 64'h6,    64'hBEEF,            64'h0,                   0, 1, -1, 1'b0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,                 1'b0};
        table_v[8]  = '{2'b01, 2'd1, 1'b1, 64'h2,    64'h0,               64'h0000_0000_8765_0000, 0, 0, -1, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_8765, 1'b0};
        table_v[9]  = '{2'b01, 2'd1, 1'b0, 64'h2,    64'h0,               64'h0000_0000_8765_0000, 0, 2, -1, 1'b1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8765, 1'b0};
        table_v[10] = '{2'b10, 2'd3, 1'b0, 64'h104,  64'h5,               64'h0,                   0, 0, -1, 1'b1, 8'h00, 64'h0,                 64'h0,                 1'b1};

        resetn = 1'b0; valid_i = 1'b1; mem_rw_i = 2'b01; size_i = 2'd0; unsigned_i = 1'b0;
        addr_i = 64'h0; wdata_i = 64'h0; flush_i = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'h0;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_dreq_valid", dreq_valid, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_fault_addr", fault_addr_o, 0);
        valid_i = 1'b0;
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) run(table_v[i]);

        @(posedge clk); #1;
        valid_i = 1'b1; mem_rw_i = 2'b11; addr_i = 64'h40;
        @(negedge clk);
        chk("rw11_no_stall", stall_o, 0);
        @(posedge clk); #1;
        mem_rw_i = 2'b01; flush_i = 1'b1;
        @(negedge clk);
        chk("idle_flush_no_stall", stall_o, 0);
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_req", dreq_valid, 0);
        chk("idle_flush_no_done", done_o, 0);

        @(posedge clk); #1;
        valid_i = 1'b1; mem_rw_i = 2'b01; size_i = 2'd3; addr_i = 64'h40;
        @(posedge clk); #1;
        valid_i = 1'b0; dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait_stall_before_rst", stall_o, 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("midrst_stall", stall_o, 0);
        chk("midrst_dreq_valid", dreq_valid, 0);
        chk("midrst_dreq_addr", dreq_addr, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_rdata", rdata_o, 0);
        chk("midrst_fault_addr", fault_addr_o, 0);
        last_rdata = 64'h0; rd_known = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        run(table_v[0]);

        for (int n = 0; n < 60; n++) begin
            rv.rw    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            rv.size  = 2'($urandom_range(0, 3));
            rv.uns   = 1'($urandom_range(0, 1));
            rv.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~((64'd1 << rv.size) - 64'd1);
            rv.wdata = {$urandom, $urandom};
            rv.raw   = {$urandom, $urandom};
            rv.aok   = int'($urandom_range(0, 3));
            rv.dok   = int'($urandom_range(0, 3));
            tot      = rv.aok + 1 + rv.dok;
            rv.fl_at = (tot > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, tot - 2)) : -1;
            rv.fl_done = ($urandom_range(0, 9) == 0);
            rv = model(rv);
            run(rv);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
